// File: rtl/cdc_reqack_src_if.sv
// Handshake bundle for the source end of a four-phase req/ack crossing.
// Local producer side: valid_i/data_i/ready_o. Far domain side: req_o/data_o/ack_i.
interface cdc_reqack_src_if #(
  parameter int WIDTH = 8
);
  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;
  logic             req_o;
  logic [WIDTH-1:0] data_o;
  logic             ack_i;
  logic             done_o;
  logic             busy_o;

  // The crossing block itself
  modport slave (
    input  valid_i,
    input  data_i,
    input  ack_i,
    output ready_o,
    output req_o,
    output data_o,
    output done_o,
    output busy_o
  );

  // Whoever drives the producer side and the far-domain acknowledge
  modport master (
    output valid_i,
    output data_i,
    output ack_i,
    input  ready_o,
    input  req_o,
    input  data_o,
    input  done_o,
    input  busy_o
  );
endinterface

// File: rtl/cdc_reqack_src.sv
// Source-side controller of a four-phase req/ack clock-domain crossing.
// Accepts a word with valid/ready, holds it on data_o, raises req_o and
// waits for the far side's ack (brought in through a two-flop synchronizer)
// to rise and fall again before taking the next word.
module cdc_reqack_src #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cdc_reqack_src_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ack_s1_q;
  logic             ack_sync_q;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready;
  logic             busy;
  logic             accept;

  // Two-stage synchronizer for the asynchronous acknowledge level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_s1_q   <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_s1_q   <= bus.ack_i;
      ack_sync_q <= ack_s1_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the FSM only ever looks at the synchronized ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i && !ack_sync_q) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_sync_q) begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!ack_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: ready/busy combinational, next values for registered outputs.
  // A high ack_sync in IDLE is a stale ack and simply blocks acceptance.
  always_comb begin
    ready  = (state_q == ST_IDLE) && !ack_sync_q;
    busy   = (state_q != ST_IDLE);
    accept = ready && bus.valid_i;
    req_d  = req_q;
    data_d = data_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d  = 1'b1;
          data_d = bus.data_i;
        end
      end
      ST_REQ: begin
        if (ack_sync_q) begin
          req_d = 1'b0;
        end
      end
      ST_WAIT_LOW: begin
        if (!ack_sync_q) begin
          done_d = 1'b1;
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Registered outputs; reset drops req_o at once, aborting any transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      req_q  <= req_d;
      done_q <= done_d;
      data_q <= data_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.busy_o  = busy;
  assign bus.req_o   = req_q;
  assign bus.data_o  = data_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_cdc_reqack_src.sv
// Directed bench for cdc_reqack_src: a vector table with a manually driven
// ack, then hand-written loopback, back-to-back, stale-ack, slow far side
// and mid-transfer reset sequences.
module tb_cdc_reqack_src;

  logic clk;
  logic rst;
  logic ack_man;
  logic loopback;
  int   checks;
  int   failures;

  cdc_reqack_src_if #(.WIDTH(8)) bus_if ();

  assign bus_if.ack_i = loopback ? bus_if.req_o : ack_man;

  cdc_reqack_src #(.WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] din;
    logic       ack;
    logic       ready;
    logic       req;
    logic [7:0] dout;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (bus_if.done_o) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic [7:0] b2b_vals[3];
    logic [7:0] exp_data;
    int         dones;

    clk = 1'b0;
    rst = 1'b0;
    ack_man = 1'b0;
    loopback = 1'b0;
    checks = 0;
    failures = 0;
    bus_if.valid_i = 1'b0;
    bus_if.data_i = 8'h00;

    //              valid din    ack  ready req dout   done busy
    vecs[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};

    // Reset state, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_req",   {31'd0, bus_if.req_o},  32'd0);
    chk("rst_data",  {24'd0, bus_if.data_o}, 32'd0);
    chk("rst_done",  {31'd0, bus_if.done_o}, 32'd0);
    chk("rst_busy",  {31'd0, bus_if.busy_o}, 32'd0);
    chk("rst_ready", {31'd0, bus_if.ready_o}, 32'd1);
    step();
    step();
    rst = 1'b0;
    $display("reset released at t=%0t", $time);

    // Vector table with manually driven ack
    for (int i = 0; i < 14; i++) begin
      bus_if.valid_i = vecs[i].valid;
      bus_if.data_i  = vecs[i].din;
      ack_man        = vecs[i].ack;
      step();
      $display("vec %0d: valid=%0b din=%02h ack=%0b -> ready=%0b req=%0b dout=%02h done=%0b busy=%0b",
               i, vecs[i].valid, vecs[i].din, vecs[i].ack, bus_if.ready_o, bus_if.req_o,
               bus_if.data_o, bus_if.done_o, bus_if.busy_o);
      chk("vec_ready", {31'd0, bus_if.ready_o}, {31'd0, vecs[i].ready});
      chk("vec_req",   {31'd0, bus_if.req_o},   {31'd0, vecs[i].req});
      chk("vec_data",  {24'd0, bus_if.data_o},  {24'd0, vecs[i].dout});
      chk("vec_done",  {31'd0, bus_if.done_o},  {31'd0, vecs[i].done});
      chk("vec_busy",  {31'd0, bus_if.busy_o},  {31'd0, vecs[i].busy});
    end
    bus_if.valid_i = 1'b0;

    // Single loopback transfer of 0xA5: done after edge 6, period 7
    loopback = 1'b1;
    bus_if.valid_i = 1'b1;
    bus_if.data_i  = 8'hA5;
    for (int e = 0; e <= 7; e++) begin
      step();
      bus_if.valid_i = 1'b0;
      bus_if.data_i  = 8'($urandom);
      chk("lb_req",   {31'd0, bus_if.req_o},   (e <= 2) ? 32'd1 : 32'd0);
      chk("lb_done",  {31'd0, bus_if.done_o},  (e == 6) ? 32'd1 : 32'd0);
      chk("lb_ready", {31'd0, bus_if.ready_o}, (e >= 6) ? 32'd1 : 32'd0);
      chk("lb_data",  {24'd0, bus_if.data_o},  32'hA5);
    end
    $display("loopback single transfer 0xA5 finished at t=%0t", $time);

    // Back-to-back with valid held high; data_i garbage while busy
    b2b_vals[0] = 8'h01;
    b2b_vals[1] = 8'h02;
    b2b_vals[2] = 8'h03;
    dones = 0;
    bus_if.valid_i = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      bus_if.data_i = (e % 7 == 0) ? b2b_vals[e / 7] : 8'($urandom);
      step();
      exp_data = b2b_vals[e / 7];
      if (bus_if.done_o) dones++;
      chk("b2b_data",  {24'd0, bus_if.data_o},  {24'd0, exp_data});
      chk("b2b_req",   {31'd0, bus_if.req_o},   ((e % 7) <= 2) ? 32'd1 : 32'd0);
      chk("b2b_ready", {31'd0, bus_if.ready_o}, ((e % 7) == 6) ? 32'd1 : 32'd0);
    end
    bus_if.valid_i = 1'b0;
    chk("b2b_dones", dones, 32'd3);
    $display("back-to-back 01/02/03: %0d done pulses", dones);

    // Stale ack in IDLE blocks acceptance until it is released
    loopback = 1'b0;
    ack_man = 1'b1;
    step();
    chk("stale_ready_e0", {31'd0, bus_if.ready_o}, 32'd1);
    step();
    chk("stale_ready_e1", {31'd0, bus_if.ready_o}, 32'd0);
    bus_if.valid_i = 1'b1;
    bus_if.data_i  = 8'h77;
    for (int e = 2; e <= 4; e++) begin
      step();
      chk("stale_ready", {31'd0, bus_if.ready_o}, 32'd0);
      chk("stale_req",   {31'd0, bus_if.req_o},   32'd0);
      chk("stale_busy",  {31'd0, bus_if.busy_o},  32'd0);
    end
    ack_man = 1'b0;
    step();
    chk("stale_rel_ready1", {31'd0, bus_if.ready_o}, 32'd0);
    step();
    chk("stale_rel_ready2", {31'd0, bus_if.ready_o}, 32'd1);
    chk("stale_rel_req2",   {31'd0, bus_if.req_o},   32'd0);
    step();
    bus_if.valid_i = 1'b0;
    chk("stale_acc_req",  {31'd0, bus_if.req_o},  32'd1);
    chk("stale_acc_data", {24'd0, bus_if.data_o}, 32'h77);
    loopback = 1'b1;
    wait_done("stale_done", 20);
    $display("stale-ack sequence complete at t=%0t", $time);

    // Slow far side: ack rises 20 cycles after req, falls 15 after req falls
    loopback = 1'b0;
    ack_man = 1'b0;
    step();
    for (int e = 0; e <= 40; e++) begin
      bus_if.valid_i = (e == 0);
      bus_if.data_i  = (e == 0) ? 8'h42 : 8'($urandom);
      ack_man = (e >= 20 && e < 37);
      step();
      chk("slow_req",   {31'd0, bus_if.req_o},   (e <= 21) ? 32'd1 : 32'd0);
      chk("slow_done",  {31'd0, bus_if.done_o},  (e == 39) ? 32'd1 : 32'd0);
      chk("slow_busy",  {31'd0, bus_if.busy_o},  (e <= 38) ? 32'd1 : 32'd0);
      chk("slow_data",  {24'd0, bus_if.data_o},  32'h42);
    end
    bus_if.valid_i = 1'b0;
    $display("slow far-side transfer 0x42 finished at t=%0t", $time);

    // Reset mid-REQ: asynchronous drop, no done, then a clean transfer
    bus_if.valid_i = 1'b1;
    bus_if.data_i  = 8'h99;
    step();
    bus_if.valid_i = 1'b0;
    chk("mr_req_before", {31'd0, bus_if.req_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_req",   {31'd0, bus_if.req_o},   32'd0);
    chk("mr_data",  {24'd0, bus_if.data_o},  32'd0);
    chk("mr_busy",  {31'd0, bus_if.busy_o},  32'd0);
    chk("mr_done",  {31'd0, bus_if.done_o},  32'd0);
    chk("mr_ready", {31'd0, bus_if.ready_o}, 32'd1);
    step();
    step();
    chk("mr_done_held", {31'd0, bus_if.done_o}, 32'd0);
    rst = 1'b0;
    step();
    chk("mr_post_ready", {31'd0, bus_if.ready_o}, 32'd1);
    chk("mr_post_done",  {31'd0, bus_if.done_o},  32'd0);
    loopback = 1'b1;
    bus_if.valid_i = 1'b1;
    bus_if.data_i  = 8'h3C;
    step();
    bus_if.valid_i = 1'b0;
    chk("mr_new_req",  {31'd0, bus_if.req_o},  32'd1);
    chk("mr_new_data", {24'd0, bus_if.data_o}, 32'h3C);
    wait_done("mr_new_done", 20);
    $display("reset mid-REQ sequence complete at t=%0t", $time);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_reqack_src.md
# cdc_reqack_src

Source-side controller for a four-phase req/ack clock-domain crossing. It accepts a data word from the local domain with a valid/ready handshake and holds it stable on `data_o`. It drives a level request to the far domain and brings the far domain's acknowledge back through an internal two-stage synchronizer. The block is the sending end paired with the destination-side two-flop synchronizer, which samples `req_o` and `data_o` in its own clock.

## Interface
- `WIDTH`, default 8: width of the transferred data word.
- `clk_i`  in  1: local (source) clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `valid_i`  in  1: local producer has a word on `data_i`.
- `data_i`  in  WIDTH: word to transfer; sampled only on acceptance.
- `ready_o`  out  1: block can accept a word this cycle.
- `req_o`  out  1: registered four-phase request level to the far domain.
- `data_o`  out  WIDTH: registered held data, stable from `req_o` rise until the next acceptance.
- `ack_i`  in  1: acknowledge level from the far domain; asynchronous to `clk_i`.
- `done_o`  out  1: one-cycle pulse when a four-phase cycle completes.
- `busy_o`  out  1: high whenever the state is not IDLE.

## Operation
- `ack_i` passes through two flops, `ack_s1` then `ack_sync`, both reset to 0. The FSM uses only `ack_sync` and never reads `ack_i` directly.
- The FSM has three states: IDLE, REQ and WAIT_LOW.
- **IDLE:**
  - `ready_o = !ack_sync`, combinational from state and `ack_sync`.
  - On `valid_i && ready_o`: `data_o <= data_i`, `req_o <= 1`, and the state goes to REQ.
  - If `ack_sync` is high in IDLE, the block does not accept new data. This ack is stale or spurious. It is otherwise ignored.
- **REQ:**
  - `req_o` stays 1 and `ready_o` is 0.
  - When `ack_sync == 1`: `req_o <= 0` and the state goes to WAIT_LOW.
- **WAIT_LOW:**
  - `req_o` is 0 and `ready_o` is 0.
  - When `ack_sync == 0`: the state goes to IDLE and `done_o <= 1` for exactly one cycle.
- `data_o` is only written on acceptance. It is never cleared except by reset.
- `valid_i` and `data_i` are don't-care outside an accepting cycle. A producer holding `valid_i` high while the block is busy causes no effect.
- `busy_o = (state != IDLE)`.
- **Reset:**
  - While `rst_i` is asserted: state IDLE, `req_o=0`, `data_o=0`, `done_o=0`, `ack_s1=0`, `ack_sync=0`, `busy_o=0`.
  - `ready_o` is 1 after reset.
  - Reset asserted mid-transfer drops `req_o` immediately, asynchronously. The far side sees an aborted request. No `done_o` is produced.

## Timing
- Acceptance at edge N gives `req_o=1` and the new `data_o` after edge N.
- `data_o` is updated on the same edge as `req_o` rises. The far side may sample `data_o` once its synchronized req is high.
- Ack latency: an `ack_i` change that meets setup before edge M is in `ack_s1` after M and in `ack_sync` after M+1. The FSM acts on it at edge M+2.
- Loopback, with `ack_i` tied to `req_o` in the same clock:
  - Acceptance at edge 0.
  - `req_o` falls after edge 3.
  - The state returns to IDLE and `done_o` is high after edge 6.
  - Next acceptance at edge 7, giving a period of 7 cycles.
- `done_o` is high in the same cycle that `ready_o` first returns to 1. A new word may be accepted on the edge ending that cycle.
- All outputs except `ready_o` and `busy_o` come directly from flops. `ready_o` and `busy_o` are decoded from registered state and `ack_sync`.

## Test plan
- **Single transfer, loopback `ack_i = req_o`:** `valid_i=1`, `data_i=0xA5` at edge 0 → `req_o` high cycles 1–3, `data_o=0xA5` from cycle 1, `done_o` pulse in cycle 7 only, `ready_o` 0 in cycles 1–6.
- **Back-to-back, `valid_i` held high, `data_i` sequence 0x01, 0x02, 0x03 (loopback):** → accepts at edges 0, 7, 14. `data_o` goes 0x01 → 0x02 → 0x03, with exactly three `done_o` pulses.
- **Data stability:** change `data_i` every cycle while busy → `data_o` stays at the accepted value until the next acceptance.
- **Stale ack:** hold `ack_i=1` in IDLE with `valid_i=1` → after 2 cycles `ready_o=0` and no acceptance. Release `ack_i` → `ready_o=1` 2 cycles later and the transfer proceeds.
- **Slow far side:** `ack_i` rises 20 cycles after `req_o` and falls 15 cycles after `req_o` falls → `req_o` falls exactly 3 cycles after `ack_i` rises. `done_o` pulses exactly 3 cycles after `ack_i` falls.
- **Reset mid-REQ:** assert `rst_i` while `req_o=1` → `req_o`, `data_o` and `busy_o` go to 0 without a clock edge, and no `done_o`. After release, `ready_o=1` and a new transfer completes normally.
